// File: rtl/pu_msp430_per_master.sv
// Peripheral-bus initiator: runs single or burst byte/word reads and writes on the
// per_addr/per_din/per_en/per_we/per_dout bus, fed by a command port and ready/valid data streams.
module pu_msp430_per_master #(
    parameter int LEN_WD = 4
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_byte,
    input  logic [14:0]       cmd_addr,
    input  logic [LEN_WD-1:0] cmd_len,
    input  logic [15:0]       wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [15:0]       rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              busy,
    output logic              done,
    output logic [13:0]       per_addr,
    output logic [15:0]       per_din,
    output logic              per_en,
    output logic [1:0]        per_we,
    input  logic [15:0]       per_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_write;
    logic                r_byte;
    logic [14:0]         r_addr;
    logic [LEN_WD-1:0]   r_cnt;
    logic                r_rd_left;
    logic [15:0]         r_rdata;
    logic                r_rdata_valid;
    logic                w_per_en;
    logic                w_last;
    logic [14:0]         w_step;

    // Byte reads return the addressed lane zero-extended; word reads pass through.
    function automatic logic [15:0] read_lane(input logic is_byte, input logic hi,
                                              input logic [15:0] d);
        if (!is_byte)
            return d;
        return {8'h00, hi ? d[15:8] : d[7:0]};
    endfunction

    always_ff @(posedge mclk) begin
        if (puc_rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_per_en     = 1'b0;
        w_last       = (r_cnt == '0);
        unique case (r_state)
            IDLE: begin
                if (cmd_valid)
                    w_next_state = XFER;
            end
            XFER: begin
                if (r_write) begin
                    w_per_en = wdata_valid;
                    if (w_per_en && w_last)
                        w_next_state = DONE;
                end else begin
                    w_per_en = (~r_rdata_valid | rdata_ready) & r_rd_left;
                    // Reads finish only once the final captured word has been taken.
                    if (!r_rd_left && r_rdata_valid && rdata_ready)
                        w_next_state = DONE;
                end
            end
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_step = r_byte ? 15'd1 : 15'd2;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_write       <= 1'b0;
            r_byte        <= 1'b0;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_rd_left     <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_write   <= cmd_write;
                r_byte    <= cmd_byte;
                r_addr    <= cmd_byte ? cmd_addr : {cmd_addr[14:1], 1'b0};
                r_cnt     <= cmd_len;
                r_rd_left <= ~cmd_write;
            end
            if (w_per_en) begin
                r_addr <= r_addr + w_step;
                r_cnt  <= r_cnt - 1'b1;
                if (w_last)
                    r_rd_left <= 1'b0;
            end
            if (w_per_en && !r_write) begin
                r_rdata       <= read_lane(r_byte, r_addr[0], per_dout);
                r_rdata_valid <= 1'b1;
            end else if (r_rdata_valid && rdata_ready) begin
                r_rdata_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        per_din = 16'h0000;
        per_we  = 2'b00;
        if (w_per_en && r_write) begin
            per_din = r_byte ? {wdata[7:0], wdata[7:0]} : wdata;
            per_we  = r_byte ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        end
    end

    assign per_en      = w_per_en;
    assign per_addr    = r_addr[14:1];
    assign wdata_ready = w_per_en & r_write;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

endmodule
